alu_instr_decoder: RTL and testbench
====================================

# alu_instr_decoder

Registered decode stage that turns 32-bit instruction words into the control bundle the ALU consumes: opcode, condition, S, shift control, shift amount, immediate, plus register indices and write enables. Sits between instruction fetch and the register-read/ALU stage. Uses valid/ready handshakes on both sides, so a held output stalls fetch. An optional load-use interlock stalls fetch while a pending LDR destination is still being loaded.

## Interface
- `LOAD_LAT`, default 2: cycles a loaded register stays unavailable after its LDR is accepted; legal range 1–15.
- `clk` in, 1 bit: clock; all state updates on its rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `in_valid` / `in_ready`, in / out, 1 bit each: instruction handshake.
- `instr` in, 32 bits: instruction word.
- `out_valid` / `out_ready`, out / in, 1 bit each: decoded-bundle handshake.
- `opcode` out 4, `cond` out 4, `s` out 1, `sr_cont` out 3, `sr_bit` out 5, `imm` out 16: ALU control fields.
- `rd`, `rn`, `rm` out, 5 bits each: register indices.
- `reg_we` out 1, `flags_we` out 1, `mem_rd` out 1, `mem_wr` out 1, `illegal` out 1: decode qualifiers.
- `err_sticky` out, 1 bit: set on any accepted illegal instruction; cleared only by `rst`.

## Operation
- Instruction fields:
  - `[31:28]` opcode; `[27:24]` cond; `[23]` S; `[22:18]` rd; `[17:13]` rn; `[12:8]` rm; `[7:5]` sr_cont; `[4:0]` sr_bit.
  - `imm` = `[15:0]`, always driven.
- Legal opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 ORR, 0100 AND, 0101 EOR
  - 0110 MOVI, 0111 MOV, 1011 CMP, 1101 LDR, 1110 STR
  - All other opcodes are illegal.
- Legal cond: 0000–1000. Any cond above 1000 is illegal.
- `reg_we` = 1 for ADD–EOR, MOVI, MOV, LDR.
- `flags_we` = `s` for ADD–EOR; always 1 for CMP; 0 otherwise.
- `mem_rd` = 1 for LDR only. `mem_wr` = 1 for STR only.
- Illegal instruction: bundle is still emitted with `illegal`=1 and `reg_we`/`flags_we`/`mem_rd`/`mem_wr` forced to 0. `err_sticky` sets in the same cycle as acceptance.
- Source registers:
  - rn: every opcode except MOVI.
  - rm: ADD–EOR and CMP.
  - rd: STR (store data).
- Pipeline register: a single entry. `in_ready = (!out_valid || out_ready) && !stall`.
  - Accept: latches the decoded bundle and sets `out_valid`.
  - `out_valid && out_ready` with no new accept: clears `out_valid`.
  - Simultaneous accept and drain: replaces the bundle; `out_valid` stays 1 (full throughput).
- When `out_valid`=1 and `out_ready`=0, every output holds stable.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Throughput: 1 instruction per cycle when there is no backpressure or stall.
- Reset values: `out_valid`=0, every field output 0, `illegal`=0, `err_sticky`=0, hazard counter 0. Reset is immediate on assertion of `rst`.
- Reset mid-operation discards the held bundle and any pending hazard.
- `in_ready` is combinational from `out_ready`, `out_valid` and the hazard state.

## Configuration
- Macro: `ALU_DEC_HAZARD_EN`.
- Defined:
  - Accepting an LDR loads `ld_cnt` = `LOAD_LAT` and `ld_rd` = rd.
  - `ld_cnt` decrements by 1 every cycle while nonzero.
  - `stall` = (`ld_cnt` ≠ 0) AND any source register of `instr` equals `ld_rd`.
  - A new LDR accepted while `ld_cnt` ≠ 0 reloads both `ld_cnt` and `ld_rd`.
  - Illegal instructions never stall.
- Undefined: `stall` is tied to 0. No counter or `ld_rd` register is built.

## Structure
- Package `alu_pkg` holds:
  - Opcode and cond localparams.
  - Field bit positions.
  - Decoded-bundle packed-struct typedef.
- Sub-module `alu_field_decode`: purely combinational, `instr` → bundle + `illegal`.
- Top module holds the handshake register, the hazard counter and `err_sticky`.

## Test plan
- Reset, then `in_valid`=1 with 0x008C2244, `out_ready`=1.
  - Next cycle: opcode 0000, s 1, rd 3, rn 1, rm 2, sr_cont 010, sr_bit 4, reg_we 1, flags_we 1.
- 0x6014BEEF with `out_ready`=0 for 3 cycles.
  - opcode 0110, rd 5, imm 0xBEEF, reg_we 1, flags_we 0.
  - Outputs held stable and `in_ready`=0 until `out_ready` rises.
- 0xF0000000.
  - `illegal`=1, all enables 0, `err_sticky`=1.
  - `err_sticky` survives 10 further legal instructions.
- 0xD0102000 (LDR r4) immediately followed by 0x00188200 (ADD r6,r4,r2), `ALU_DEC_HAZARD_EN` defined, `LOAD_LAT`=2.
  - ADD stalls 2 cycles, then is accepted.
  - Without the macro, ADD is accepted on the next cycle.
- Streaming 8 legal instructions with `out_ready`=1 and no hazards: one bundle per cycle, no bubbles.
- Assert `rst` while `out_valid`=1 and `ld_cnt`=2: `out_valid`=0 and `ld_cnt`=0 immediately after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU instruction decoder:
//   - opcode and condition code values
//   - bit positions of every field in the 32-bit instruction word
//   - alu_bundle_t, the decoded control bundle handed to the ALU stage
//   - is_alu_op(), true for the two-operand ALU group ADD..EOR
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_EOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_LDR  = 4'b1101;
    localparam logic [3:0] OP_STR  = 4'b1110;

    // Highest legal condition code; anything above is illegal
    localparam logic [3:0] COND_MAX = 4'b1000;

    // Field bit positions
    localparam int OPC_LO = 28;
    localparam int CND_LO = 24;
    localparam int S_BIT  = 23;
    localparam int RD_LO  = 18;
    localparam int RN_LO  = 13;
    localparam int RM_LO  = 8;
    localparam int SRC_LO = 5;
    localparam int SRB_LO = 0;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  cond;
        logic        s;
        logic [2:0]  sr_cont;
        logic [4:0]  sr_bit;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        reg_we;
        logic        flags_we;
        logic        mem_rd;
        logic        mem_wr;
    } alu_bundle_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_EOR);
    endfunction

endpackage

// File: rtl/alu_field_decode.sv
// -----------------------------------------------------------------------------
// alu_field_decode
// Purely combinational field extraction and legality check for one
// instruction word.
// Ports:
//   i_instr    [31:0] instruction word
//   o_bundle          decoded control bundle (qualifiers zeroed when illegal)
//   o_illegal         unknown opcode or condition code above COND_MAX
//   o_use_rn          instruction reads rn
//   o_use_rm          instruction reads rm
//   o_use_rd          instruction reads rd (store data for STR)
// -----------------------------------------------------------------------------
module alu_field_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output alu_bundle_t o_bundle,
    output logic        o_illegal,
    output logic        o_use_rn,
    output logic        o_use_rm,
    output logic        o_use_rd
);

    logic [3:0] w_op;
    logic       w_legal_op;
    logic       w_legal_cond;

    assign w_op = i_instr[OPC_LO +: 4];

    always_comb begin
        o_bundle     = '0;
        w_legal_op   = 1'b0;
        o_use_rn     = 1'b0;
        o_use_rm     = 1'b0;
        o_use_rd     = 1'b0;

        // Raw fields are always passed through, even for illegal words
        o_bundle.opcode  = w_op;
        o_bundle.cond    = i_instr[CND_LO +: 4];
        o_bundle.s       = i_instr[S_BIT];
        o_bundle.rd      = i_instr[RD_LO +: 5];
        o_bundle.rn      = i_instr[RN_LO +: 5];
        o_bundle.rm      = i_instr[RM_LO +: 5];
        o_bundle.sr_cont = i_instr[SRC_LO +: 3];
        o_bundle.sr_bit  = i_instr[SRB_LO +: 5];
        o_bundle.imm     = i_instr[IMM_LO +: 16];

        if (is_alu_op(w_op)) begin
            w_legal_op        = 1'b1;
            o_bundle.reg_we   = 1'b1;
            o_bundle.flags_we = i_instr[S_BIT];
            o_use_rn          = 1'b1;
            o_use_rm          = 1'b1;
        end else begin
            case (w_op)
                OP_MOVI: begin
                    w_legal_op      = 1'b1;
                    o_bundle.reg_we = 1'b1;
                end
                OP_MOV: begin
                    w_legal_op      = 1'b1;
                    o_bundle.reg_we = 1'b1;
                    o_use_rn        = 1'b1;
                end
                OP_CMP: begin
                    w_legal_op        = 1'b1;
                    o_bundle.flags_we = 1'b1;
                    o_use_rn          = 1'b1;
                    o_use_rm          = 1'b1;
                end
                OP_LDR: begin
                    w_legal_op      = 1'b1;
                    o_bundle.reg_we = 1'b1;
                    o_bundle.mem_rd = 1'b1;
                    o_use_rn        = 1'b1;
                end
                OP_STR: begin
                    w_legal_op      = 1'b1;
                    o_bundle.mem_wr = 1'b1;
                    o_use_rn        = 1'b1;
                    o_use_rd        = 1'b1;
                end
                default: begin
                    // Unknown opcode: rn is still nominally a source, but an
                    // illegal word never takes part in hazard checks anyway.
                    o_use_rn = 1'b1;
                end
            endcase
        end

        w_legal_cond = (o_bundle.cond <= COND_MAX);
        o_illegal    = !(w_legal_op && w_legal_cond);

        // An illegal bundle must not write anything downstream
        if (o_illegal) begin
            o_bundle.reg_we   = 1'b0;
            o_bundle.flags_we = 1'b0;
            o_bundle.mem_rd   = 1'b0;
            o_bundle.mem_wr   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_instr_decoder.sv
// -----------------------------------------------------------------------------
// alu_instr_decoder
// Registered decode stage between instruction fetch and register-read/ALU.
// One-entry pipeline register with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1. in_ready = (!out_valid || out_ready) && !stall, so a held output
// stalls fetch, and a simultaneous drain + accept keeps full throughput.
//
// Optional feature (macro ALU_DEC_HAZARD_EN): load-use interlock. Accepting an
// LDR arms a countdown of LOAD_LAT cycles (legal 1..15) on its rd; while the
// countdown is nonzero, any legal instruction reading that register stalls.
// Without the macro, stall is tied low and no hazard state exists.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid, in_ready, instr instruction handshake and word
//   out_valid, out_ready      decoded-bundle handshake
//   opcode, cond, s, sr_cont, sr_bit, imm   ALU control fields
//   rd, rn, rm                register indices
//   reg_we, flags_we, mem_rd, mem_wr, illegal  decode qualifiers
//   err_sticky                set by any accepted illegal word, cleared by rst
// -----------------------------------------------------------------------------
module alu_instr_decoder
    import alu_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  opcode,
    output logic [3:0]  cond,
    output logic        s,
    output logic [2:0]  sr_cont,
    output logic [4:0]  sr_bit,
    output logic [15:0] imm,
    output logic [4:0]  rd,
    output logic [4:0]  rn,
    output logic [4:0]  rm,
    output logic        reg_we,
    output logic        flags_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        illegal,
    output logic        err_sticky
);

    alu_bundle_t w_bundle;
    logic        w_illegal;
    logic        w_use_rn;
    logic        w_use_rm;
    logic        w_use_rd;
    logic        w_stall;
    logic        w_accept;

    alu_bundle_t r_bundle;
    logic        r_illegal;
    logic        r_out_valid;
    logic        r_err_sticky;

    alu_field_decode u_field_decode (
        .i_instr   (instr),
        .o_bundle  (w_bundle),
        .o_illegal (w_illegal),
        .o_use_rn  (w_use_rn),
        .o_use_rm  (w_use_rm),
        .o_use_rd  (w_use_rd)
    );

`ifdef ALU_DEC_HAZARD_EN
    logic [3:0] r_ld_cnt;
    logic [4:0] r_ld_rd;
    logic       w_src_hit;

    always_comb begin
        w_src_hit = (w_use_rn && (w_bundle.rn == r_ld_rd)) ||
                    (w_use_rm && (w_bundle.rm == r_ld_rd)) ||
                    (w_use_rd && (w_bundle.rd == r_ld_rd));
    end

    assign w_stall = (r_ld_cnt != 4'd0) && w_src_hit && !w_illegal;

    // mem_rd is already zero for an illegal LDR, so only legal loads arm it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_cnt <= 4'd0;
            r_ld_rd  <= 5'd0;
        end else if (w_accept && w_bundle.mem_rd) begin
            r_ld_cnt <= 4'(LOAD_LAT);
            r_ld_rd  <= w_bundle.rd;
        end else if (r_ld_cnt != 4'd0) begin
            r_ld_cnt <= r_ld_cnt - 4'd1;
        end
    end
`else
    logic w_unused_hazard;
    assign w_unused_hazard = ^{w_use_rn, w_use_rm, w_use_rd, 32'(LOAD_LAT)};
    assign w_stall = 1'b0;
`endif

    assign in_ready = (!r_out_valid || out_ready) && !w_stall;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_bundle;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign out_valid  = r_out_valid;
    assign opcode     = r_bundle.opcode;
    assign cond       = r_bundle.cond;
    assign s          = r_bundle.s;
    assign sr_cont    = r_bundle.sr_cont;
    assign sr_bit     = r_bundle.sr_bit;
    assign imm        = r_bundle.imm;
    assign rd         = r_bundle.rd;
    assign rn         = r_bundle.rn;
    assign rm         = r_bundle.rm;
    assign reg_we     = r_bundle.reg_we;
    assign flags_we   = r_bundle.flags_we;
    assign mem_rd     = r_bundle.mem_rd;
    assign mem_wr     = r_bundle.mem_wr;
    assign illegal    = r_illegal;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_alu_instr_decoder.sv
module tb_alu_instr_decoder;

  localparam int W = 53;

  // {we, flags_we, mem_rd, mem_wr, illegal}
  localparam logic [4:0] Q_NONE = 5'b00000;
  localparam logic [4:0] Q_WE   = 5'b10000;
  localparam logic [4:0] Q_WEF  = 5'b11000;
  localparam logic [4:0] Q_F    = 5'b01000;
  localparam logic [4:0] Q_LD   = 5'b10100;
  localparam logic [4:0] Q_ST   = 5'b00010;
  localparam logic [4:0] Q_ILL  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  opcode, cond;
  logic        s;
  logic [2:0]  sr_cont;
  logic [4:0]  sr_bit;
  logic [15:0] imm;
  logic [4:0]  rd, rn, rm;
  logic        reg_we, flags_we, mem_rd, mem_wr, illegal, err_sticky;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_word;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  alu_instr_decoder #(.LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .cond(cond), .s(s), .sr_cont(sr_cont), .sr_bit(sr_bit),
    .imm(imm), .rd(rd), .rn(rn), .rm(rm),
    .reg_we(reg_we), .flags_we(flags_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .illegal(illegal), .err_sticky(err_sticky)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  assign act_word = {opcode, cond, s, sr_cont, sr_bit, imm, rd, rn, rm,
                     reg_we, flags_we, mem_rd, mem_wr, illegal};

  function automatic logic [W-1:0] mk(input logic [3:0] op, input logic [3:0] cd,
                                      input logic sb, input logic [2:0] sc,
                                      input logic [4:0] sa, input logic [15:0] im,
                                      input logic [4:0] d, input logic [4:0] n,
                                      input logic [4:0] m, input logic [4:0] q);
    return {op, cd, sb, sc, sa, im, d, n, m, q};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL bundle: unexpected output %h with empty queue", act_word);
      end else begin
        check("bundle", 64'(act_word), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] ins, input logic [W-1:0] exp_w, output int acc);
    int waited;
    bit done;
    waited = 0;
    done = 0;
    acc = -1;
    in_valid = 1'b1;
    instr = ins;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp_w);
        acc = cyc;
        done = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          compared++;
          mismatched++;
          $display("FAIL accept_timeout: instr %h not accepted in 50 cycles", ins);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0]  s_ins [10];
  logic [W-1:0] s_exp [10];
  int acc_c [10];
  int a0, a1, c0;
  logic [W-1:0] e_movi, e_ldr, e_add;

  initial begin
    s_ins[0] = 32'h10000000; s_exp[0] = mk(4'h1, 4'h0, 1'b0, 3'd0, 5'd0,  16'h0000, 5'd0,  5'd0,  5'd0, Q_WE);
    s_ins[1] = 32'h20800000; s_exp[1] = mk(4'h2, 4'h0, 1'b1, 3'd0, 5'd0,  16'h0000, 5'd0,  5'd0,  5'd0, Q_WEF);
    s_ins[2] = 32'h38000000; s_exp[2] = mk(4'h3, 4'h8, 1'b0, 3'd0, 5'd0,  16'h0000, 5'd0,  5'd0,  5'd0, Q_WE);
    s_ins[3] = 32'h47000000; s_exp[3] = mk(4'h4, 4'h7, 1'b0, 3'd0, 5'd0,  16'h0000, 5'd0,  5'd0,  5'd0, Q_WE);
    s_ins[4] = 32'h5000001F; s_exp[4] = mk(4'h5, 4'h0, 1'b0, 3'd0, 5'd31, 16'h001F, 5'd0,  5'd0,  5'd0, Q_WE);
    s_ins[5] = 32'h70FC0000; s_exp[5] = mk(4'h7, 4'h0, 1'b1, 3'd0, 5'd0,  16'h0000, 5'd31, 5'd0,  5'd0, Q_WE);
    s_ins[6] = 32'hB0800000; s_exp[6] = mk(4'hB, 4'h0, 1'b1, 3'd0, 5'd0,  16'h0000, 5'd0,  5'd0,  5'd0, Q_F);
    s_ins[7] = 32'hE003E000; s_exp[7] = mk(4'hE, 4'h0, 1'b0, 3'd0, 5'd0,  16'hE000, 5'd0,  5'd31, 5'd0, Q_ST);
    s_ins[8] = s_ins[0];     s_exp[8] = s_exp[0];
    s_ins[9] = s_ins[1];     s_exp[9] = s_exp[1];

    e_movi = mk(4'h6, 4'h0, 1'b0, 3'b111, 5'd15, 16'hBEEF, 5'd5, 5'd5, 5'd30, Q_WE);
    e_ldr  = mk(4'hD, 4'h0, 1'b0, 3'd0, 5'd0, 16'h2000, 5'd4, 5'd1, 5'd0, Q_LD);
    e_add  = mk(4'h0, 4'h0, 1'b0, 3'd0, 5'd0, 16'h8200, 5'd6, 5'd4, 5'd2, Q_WE);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fields", 64'(act_word), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // ADD with S, shift fields
    send(32'h008C2244, mk(4'h0, 4'h0, 1'b1, 3'b010, 5'd4, 16'h2244, 5'd3, 5'd1, 5'd2, Q_WEF), a0);
    idle(2);

    // MOVI under 3 cycles of backpressure
    out_ready = 1'b0;
    send(32'h6014BEEF, e_movi, a0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_fields", 64'(act_word), 64'(e_movi));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(2);

    // Illegal opcode sets err_sticky with the bundle
    check("sticky_before", 64'(err_sticky), 64'd0);
    send(32'hF0000000, mk(4'hF, 4'h0, 1'b0, 3'd0, 5'd0, 16'h0000, 5'd0, 5'd0, 5'd0, Q_ILL), a0);
    check("sticky_set", 64'(err_sticky), 64'd1);

    // 10 legal back-to-back; first 8 must stream without bubbles
    for (int i = 0; i < 10; i++) send(s_ins[i], s_exp[i], acc_c[i]);
    for (int i = 1; i < 8; i++) check("stream_gap", 64'(acc_c[i] - acc_c[i-1]), 64'd1);
    idle(1);
    check("sticky_kept", 64'(err_sticky), 64'd1);

    // Condition code just above the legal range, and an unused opcode
    send(32'h49000000, mk(4'h4, 4'h9, 1'b0, 3'd0, 5'd0, 16'h0000, 5'd0, 5'd0, 5'd0, Q_ILL), a0);
    send(32'h88000000, mk(4'h8, 4'h8, 1'b0, 3'd0, 5'd0, 16'h0000, 5'd0, 5'd0, 5'd0, Q_ILL), a0);
    idle(2);

    // Load-use: LDR r4 then ADD r6,r4,r2
    send(32'hD0102000, e_ldr, a0);
    send(32'h00188200, e_add, a1);
`ifdef ALU_DEC_HAZARD_EN
    check("ldr_add_gap", 64'(a1 - a0), 64'd3);
`else
    check("ldr_add_gap", 64'(a1 - a0), 64'd1);
`endif
    idle(3);

    // Reset while holding a bundle with a fresh load pending
    out_ready = 1'b0;
    send(32'hD0102000, e_ldr, a0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_sticky", 64'(err_sticky), 64'd1);
`ifdef ALU_DEC_HAZARD_EN
    check("pre_rst_ld_cnt", 64'(dut.r_ld_cnt), 64'd2);
`endif
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_fields", 64'(act_word), 64'd0);
    check("mid_rst_sticky", 64'(err_sticky), 64'd0);
`ifdef ALU_DEC_HAZARD_EN
    check("mid_rst_ld_cnt", 64'(dut.r_ld_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    c0 = cyc;
    send(32'h00188200, e_add, a1);
    check("post_rst_no_stall", 64'(a1), 64'(c0));
    idle(3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
